// File: rtl/exec_pkg.sv
// Shared select codes and skid-buffer state encoding for the execute operand-select stage.
package exec_pkg;

    localparam logic [2:0] SEL_RF    = 3'd0;
    localparam logic [2:0] SEL_MEM   = 3'd1;
    localparam logic [2:0] SEL_IMM   = 3'd2;
    localparam logic [2:0] SEL_CONST = 3'd3;
    localparam logic [2:0] SEL_SEXT  = 3'd4;
    localparam logic [2:0] SEL_SFILL = 3'd5;
    localparam logic [2:0] SEL_ZERO  = 3'd6;
    localparam logic [2:0] SEL_ONES  = 3'd7;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/exec_opsel_skid.sv
// Generic 2-entry skid buffer; ready is registered so nothing combinational runs from out_ready to in_ready.
//   state | meaning
//   EMPTY | no pair held, output invalid
//   ONE   | output register holds a pair
//   FULL  | output and skid registers both hold pairs, upstream stalled
module exec_opsel_skid
    import exec_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         valid_q, valid_d;
    logic         ready_q, ready_d;
    logic         acc;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        acc     = in_valid & ready_q;
        case (state_q)
            SKID_EMPTY: begin
                if (acc) begin
                    out_d   = in_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (acc && out_ready) begin
                    out_d = in_data;
                end else if (acc) begin
                    skid_d  = in_data;
                    state_d = SKID_FULL;
                end else if (out_ready) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_ready) begin
                    out_d   = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        valid_d = (state_d != SKID_EMPTY);
        ready_d = (state_d != SKID_FULL);
    end

    // ready resets low and rises on the first edge after reset releases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = out_q;

endmodule

// File: rtl/exec_opsel_pipe.sv
// Execute operand-select stage: two source muxes, memory-stall gating and a skid buffer toward the ALU.
module exec_opsel_pipe
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CONST_K = 2
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iValid,
    output logic              oReady,
    input  logic [2:0]        iSelIn1,
    input  logic [2:0]        iSelIn2,
    input  logic [DATA_W-1:0] iRF1,
    input  logic [DATA_W-1:0] iRF2,
    input  logic [DATA_W-1:0] iMem,
    input  logic              iMemValid,
    input  logic [DATA_W-1:0] iImm1,
    input  logic [DATA_W-1:0] iImm2,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oR1,
    output logic [DATA_W-1:0] oR2,
    output logic              oMemWait
);

    localparam int unsigned       H       = DATA_W / 2;
    localparam logic [DATA_W-1:0] CONST_V = DATA_W'(CONST_K);

    function automatic logic [DATA_W-1:0] pick(
        input logic [2:0]        sel,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] imm
    );
        logic [DATA_W-1:0] r;
        case (sel)
            SEL_RF:    r = rf;
            SEL_MEM:   r = mem;
            SEL_IMM:   r = imm;
            SEL_CONST: r = CONST_V;
            SEL_SEXT:  r = {{H{rf[H-1]}}, rf[H-1:0]};
            SEL_SFILL: r = {DATA_W{rf[DATA_W-1]}};
            SEL_ZERO:  r = '0;
            SEL_ONES:  r = '1;
            default:   r = '0;
        endcase
        return r;
    endfunction

    logic [DATA_W-1:0]   op1, op2;
    logic                need_mem;
    logic                mem_ok;
    logic                skid_ready;
    logic [2*DATA_W-1:0] out_pair;

    // immediates are cross-wired: operand 1 reads iImm2, operand 2 reads iImm1
    always_comb begin
        op1      = pick(iSelIn1, iRF1, iMem, iImm2);
        op2      = pick(iSelIn2, iRF2, iMem, iImm1);
        need_mem = (iSelIn1 == SEL_MEM) | (iSelIn2 == SEL_MEM);
        mem_ok   = ~need_mem | iMemValid;
    end

    exec_opsel_skid #(
        .W(2 * DATA_W)
    ) u_skid (
        .clk      (iClk),
        .rst      (iReset),
        .in_valid (iValid & mem_ok),
        .in_ready (skid_ready),
        .in_data  ({op1, op2}),
        .out_valid(oValid),
        .out_ready(iReady),
        .out_data (out_pair)
    );

    assign oReady   = skid_ready;
    assign oMemWait = iValid & skid_ready & need_mem & ~iMemValid;
    assign oR1      = out_pair[2*DATA_W-1:DATA_W];
    assign oR2      = out_pair[DATA_W-1:0];

endmodule

// File: tb/tb_exec_opsel_pipe.sv
// Randomised scoreboard bench for exec_opsel_pipe plus a directed check of a 32-bit instance.
module tb_exec_opsel_pipe;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iValid, oReady, iMemValid, oValid, iReady, oMemWait;
    logic [2:0]  iSelIn1, iSelIn2;
    logic [15:0] iRF1, iRF2, iMem, iImm1, iImm2, oR1, oR2;

    logic        b_iValid, b_oReady, b_iMemValid, b_oValid, b_iReady, b_oMemWait;
    logic [2:0]  b_iSelIn1, b_iSelIn2;
    logic [31:0] b_iRF1, b_iRF2, b_iMem, b_iImm1, b_iImm2, b_oR1, b_oR2;

    always #5 iClk = ~iClk;

    exec_opsel_pipe #(.DATA_W(16), .CONST_K(2)) dut (
        .iClk(iClk), .iReset(iReset), .iValid(iValid), .oReady(oReady),
        .iSelIn1(iSelIn1), .iSelIn2(iSelIn2), .iRF1(iRF1), .iRF2(iRF2),
        .iMem(iMem), .iMemValid(iMemValid), .iImm1(iImm1), .iImm2(iImm2),
        .oValid(oValid), .iReady(iReady), .oR1(oR1), .oR2(oR2), .oMemWait(oMemWait)
    );

    exec_opsel_pipe #(.DATA_W(32), .CONST_K(4)) dut_w (
        .iClk(iClk), .iReset(iReset), .iValid(b_iValid), .oReady(b_oReady),
        .iSelIn1(b_iSelIn1), .iSelIn2(b_iSelIn2), .iRF1(b_iRF1), .iRF2(b_iRF2),
        .iMem(b_iMem), .iMemValid(b_iMemValid), .iImm1(b_iImm1), .iImm2(b_iImm2),
        .oValid(b_oValid), .iReady(b_iReady), .oR1(b_oR1), .oR2(b_oR2), .oMemWait(b_oMemWait)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    bit          obs_en = 0;
    bit          acc_seen = 0;
    int          mw_cnt = 0;
    int          rdy_mode = 0;
    logic        need, exp_mw, acc_now;
    logic [31:0] front;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // reference: plain arithmetic from the select-code rules (H = 8)
    function automatic logic [15:0] model_op(input int sel, input logic [15:0] rf,
                                             input logic [15:0] mem, input logic [15:0] imm);
        case (sel)
            0: return rf;
            1: return mem;
            2: return imm;
            3: return 16'd2;
            4: return (rf[7:0] >= 8'h80) ? (16'hFF00 + {8'h00, rf[7:0]}) : {8'h00, rf[7:0]};
            5: return (rf >= 16'h8000) ? 16'hFFFF : 16'h0000;
            6: return 16'h0000;
            default: return 16'hFFFF;
        endcase
    endfunction

    always @(posedge iClk) begin
        #1;
        case (rdy_mode)
            0: iReady = 1'b1;
            1: iReady = 1'($urandom_range(0, 1));
            default: iReady = 1'b0;
        endcase
    end

    // monitor: occupancy of the model FIFO predicts oValid/oReady; pops compare data
    always @(negedge iClk) begin
        if (obs_en && !iReset) begin
            check("oValid", 64'(oValid), 64'(exp_q.size() > 0));
            check("oReady", 64'(oReady), 64'(exp_q.size() != 2));
            need    = (iSelIn1 == 3'd1) || (iSelIn2 == 3'd1);
            exp_mw  = iValid && (exp_q.size() != 2) && need && !iMemValid;
            check("oMemWait", 64'(oMemWait), 64'(exp_mw));
            if (oMemWait) mw_cnt++;
            acc_now = iValid && (exp_q.size() != 2) && (!need || iMemValid);
            if (exp_q.size() > 0 && iReady) begin
                front = exp_q.pop_front();
                check("pair", {32'd0, oR1, oR2}, {32'd0, front});
            end
            acc_seen = acc_now;
            if (acc_now)
                exp_q.push_back({model_op(int'(iSelIn1), iRF1, iMem, iImm2),
                                 model_op(int'(iSelIn2), iRF2, iMem, iImm1)});
        end else begin
            acc_seen = 1'b0;
        end
    end

    task automatic send(input logic [2:0] s1, input logic [2:0] s2,
                        input logic [15:0] rf1, input logic [15:0] rf2, input logic [15:0] mem,
                        input logic [15:0] imm1, input logic [15:0] imm2, input int memdly);
        int  n = 0;
        bit  done = 0;
        iValid = 1'b1; iSelIn1 = s1; iSelIn2 = s2; iRF1 = rf1; iRF2 = rf2;
        iMem = mem; iImm1 = imm1; iImm2 = imm2; iMemValid = (memdly == 0);
        while (!done) begin
            @(posedge iClk);
            #1;
            if (acc_seen) begin
                done = 1;
            end else begin
                n++;
                iMemValid = (n >= memdly);
                if (n > 60) begin
                    check("send_timeout", 64'(n), 64'd60);
                    done = 1;
                end
            end
        end
        iValid = 1'b0;
        iMemValid = 1'($urandom_range(0, 1));
        iRF1 = 16'($urandom); iMem = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge iClk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge iClk);
        #1;
    endtask

    initial begin
        int m0;
        iReset = 1'b1; iValid = 0; iReady = 1; iMemValid = 0;
        iSelIn1 = 0; iSelIn2 = 0; iRF1 = 0; iRF2 = 0; iMem = 0; iImm1 = 0; iImm2 = 0;
        b_iValid = 0; b_iReady = 1; b_iMemValid = 0; b_iSelIn1 = 0; b_iSelIn2 = 0;
        b_iRF1 = 0; b_iRF2 = 0; b_iMem = 0; b_iImm1 = 0; b_iImm2 = 0;
        repeat (3) @(posedge iClk);
        #1;
        check("rst_oValid", 64'(oValid), 64'd0);
        check("rst_oR", {32'd0, oR1, oR2}, 64'd0);
        check("rst_w_oR", {b_oR1, b_oR2}, 64'd0);
        iReset = 1'b0;
        @(posedge iClk);
        #1;
        check("post_rst_oReady", 64'(oReady), 64'd1);
        obs_en = 1;

        // single request, then operand sign-extension / sign-fill boundaries
        send(3'd0, 3'd2, 16'h1234, 16'h0000, 16'h0, 16'hBEEF, 16'h5555, 0);
        drain();
        send(3'd4, 3'd5, 16'h0080, 16'h8000, 16'h0, 16'h0, 16'h0, 0);
        send(3'd4, 3'd5, 16'h007F, 16'h7FFF, 16'h0, 16'h0, 16'h0, 0);
        drain();

        // memory stall for three cycles
        m0 = mw_cnt;
        send(3'd1, 3'd6, 16'h0, 16'h0, 16'hA5A5, 16'h0, 16'h0, 3);
        check("memwait_cycles", 64'(mw_cnt - m0), 64'd3);
        drain();

        // fill to FULL with the consumer stalled; third pair waits
        rdy_mode = 2;
        @(posedge iClk); #1;
        send(3'd0, 3'd0, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0, 0);
        send(3'd0, 3'd0, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 0);
        fork
            send(3'd0, 3'd0, 16'h5555, 16'h6666, 16'h0, 16'h0, 16'h0, 0);
            begin
                repeat (4) @(posedge iClk);
                rdy_mode = 0;
            end
        join
        drain();

        // asynchronous reset while FULL
        rdy_mode = 2;
        @(posedge iClk); #1;
        send(3'd7, 3'd7, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0);
        send(3'd3, 3'd0, 16'h0, 16'h9999, 16'h0, 16'h0, 16'h0, 0);
        @(negedge iClk);
        obs_en = 0;
        #2 iReset = 1'b1;
        #1;
        check("mid_rst_oValid", 64'(oValid), 64'd0);
        check("mid_rst_oR", {32'd0, oR1, oR2}, 64'd0);
        exp_q.delete();
        rdy_mode = 0;
        @(posedge iClk); #3;
        iReset = 1'b0;
        @(posedge iClk); #1;
        check("mid_rst_oReady", 64'(oReady), 64'd1);
        obs_en = 1;

        // randomised traffic
        for (int i = 0; i < 200; i++) begin
            if (i % 16 == 0) rdy_mode = $urandom_range(0, 1);
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge iClk); #1;
            end
        end
        drain();
        obs_en = 0;

        // 32-bit instance with CONST_K=4
        @(posedge iClk); #1;
        b_iValid = 1; b_iSelIn1 = 3'd3; b_iSelIn2 = 3'd7;
        @(posedge iClk); #1;
        b_iValid = 0;
        check("w_oValid", 64'(b_oValid), 64'd1);
        check("w_const_ones", {b_oR1, b_oR2}, 64'h00000004_FFFFFFFF);
        b_iValid = 1; b_iSelIn1 = 3'd4; b_iRF1 = 32'h0000_8000; b_iSelIn2 = 3'd5; b_iRF2 = 32'h8000_0000;
        @(posedge iClk); #1;
        b_iValid = 0;
        check("w_sext_sfill", {b_oR1, b_oR2}, 64'hFFFF8000_FFFFFFFF);
        b_iValid = 1; b_iSelIn1 = 3'd1; b_iMemValid = 0;
        #1;
        check("w_memwait", 64'(b_oMemWait), 64'd1);
        b_iValid = 0;
        #1;
        check("w_memwait_idle", 64'(b_oMemWait), 64'd0);
        @(posedge iClk); #1;
        check("w_oValid_drained", 64'(b_oValid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
